// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - multi-word add/sub sequencer driving a WIDTH-bit ripple adder; optional out_ovf port under MULTIWORD_ADD_OVF_EN

// One-bit full adder cell used to build the ripple chain.
module multiword_add_seq_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// Structural ripple-carry adder: WIDTH full adders chained LSB to MSB.
module multiword_add_seq_ripple #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] c;

  assign c[0] = ci;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      multiword_add_seq_fa u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (c[i]),
        .s  (s[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  assign co = c[WIDTH];

endmodule

// Streams operands least-significant word first through the ripple adder,
// carrying between words in carry_r. Subtraction is A + ~B + 1: the +1 enters
// as the first word's carry-in, and later words inherit the inversion via sub_r.
module multiword_add_seq #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             out_last,
`ifdef MULTIWORD_ADD_OVF_EN
  output logic             out_ovf,
`endif
  output logic [IDXW-1:0]  out_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;

  logic carry_r;
  logic sub_r;

  logic             accept;
  logic             first;
  logic             sub_eff;
  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic [WIDTH-1:0] add_s;
  logic             add_co;

  // Single-entry output register: a new word may enter whenever the slot is
  // empty or is being drained in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Any word arriving in IDLE starts an operation; in BUSY in_first restarts.
  assign first = (state == IDLE) || in_first;

  // Operand conditioning for the adder: invert B for subtract and choose the
  // carry-in (subtract flag on the first word, stored carry afterwards).
  always_comb begin
    sub_eff = sub_r;
    add_ci  = carry_r;
    if (first) begin
      sub_eff = in_sub;
      add_ci  = in_sub;
    end
    add_b = sub_eff ? ~in_b : in_b;
  end

  multiword_add_seq_ripple #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a  (in_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

`ifdef MULTIWORD_ADD_OVF_EN
  logic c_into_msb;
  logic word_ovf;

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign c_into_msb = add_s[WIDTH-1] ^ in_a[WIDTH-1] ^ add_b[WIDTH-1];
  assign word_ovf   = c_into_msb ^ add_co;
`endif

  // Sequencer state, inter-word carry and the registered output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      carry_r   <= 1'b0;
      sub_r     <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_co    <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
`ifdef MULTIWORD_ADD_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        state     <= in_last ? IDLE : BUSY;
        carry_r   <= add_co;
        if (first) begin
          sub_r <= in_sub;
        end
        out_valid <= 1'b1;
        out_s     <= add_s;
        out_co    <= add_co;
        out_last  <= in_last;
        out_idx   <= first ? '0 : out_idx + {{(IDXW-1){1'b0}}, 1'b1};
`ifdef MULTIWORD_ADD_OVF_EN
        out_ovf   <= in_last && word_ovf;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
